// File: rtl/frame_unpacker_pkg.sv
// frame_unpacker_pkg
// Shared types and elaboration helpers for the frame unpacker reader.
//   state_e          : reader FSM states
//   ADDR_W           : DDR word address width
//   clog2_min1()     : counter width that never collapses to zero bits
//   pix_addr_w()     : width of the pixel index within a frame
//   words_per_frame(): DDR words needed to cover one frame
package frame_unpacker_pkg;

  localparam int unsigned ADDR_W = 24;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_VALID,
    UNPACK,
    HOLD
  } state_e;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned pix_addr_w(input int unsigned num_pixels);
    return clog2_min1(num_pixels);
  endfunction

  // The last word of a frame may be only partly used.
  function automatic int unsigned words_per_frame(input int unsigned num_pixels,
                                                  input int unsigned pixels_per_word);
    return (num_pixels + pixels_per_word - 1) / pixels_per_word;
  endfunction

endpackage

// File: rtl/frame_unpacker_frame_pacer.sv
// frame_unpacker_frame_pacer
// Inter-frame hold counter. Counts 0..CYCLES_PER_FRAME-1 while enabled and
// flags the final count so the reader leaves HOLD after exactly
// CYCLES_PER_FRAME cycles.
// Ports:
//   clk   : system clock
//   reset : synchronous active-high reset
//   load  : restart the count at 0 (asserted on entry to HOLD)
//   en    : count this cycle (reader is in HOLD)
//   done  : last hold cycle
module frame_unpacker_frame_pacer #(
  parameter int unsigned CYCLES_PER_FRAME = 2084000
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic done
);

  localparam int unsigned CW = (CYCLES_PER_FRAME > 1) ? $clog2(CYCLES_PER_FRAME) : 1;
  // With a zero budget the reader never enters HOLD, so LAST is don't-care.
  localparam logic [CW-1:0] LAST = (CYCLES_PER_FRAME > 0) ? CW'(CYCLES_PER_FRAME - 1) : '0;

  logic [CW-1:0] cnt_q, cnt_d;

  assign done = en && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = '0;
    end else if (en && !done) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/frame_unpacker_reader.sv
// frame_unpacker_reader
// Fetches packed pixel words from DDR and writes them one pixel per cycle
// into the frame BRAM write port, pacing frames to a fixed cycle budget and
// playing NUM_FRAMES frames once or in a loop.
// Ports:
//   clk, reset              : clock, synchronous active-high reset
//   start                   : level, begins playback from IDLE
//   loop_en                 : sampled at video end, 1 = wrap to frame 0
//   ddr_rd_busy             : DDR controller cannot take a request
//   ddr_rd_en, ddr_addr     : read request and its word address
//   ddr_rd_data_valid       : ddr_data valid this cycle
//   ddr_data                : packed pixel word, LSB-first
//   pix_we/pix_addr/pix_data: frame-buffer write port (registered)
//   frame_done, video_done  : one-cycle completion pulses
//   busy                    : reader not in IDLE
//   rd_timeout              : re-issue pulse (FRAME_UNPACKER_TIMEOUT_EN only)
// Optional feature macro: FRAME_UNPACKER_TIMEOUT_EN adds a WAIT_VALID
// watchdog that re-issues the same request after TIMEOUT_CYCLES cycles.
module frame_unpacker_reader
  import frame_unpacker_pkg::*;
#(
  parameter int unsigned DDR_DATA_WIDTH   = 128,
  parameter int unsigned PIXEL_WIDTH      = 24,
  parameter int unsigned PIXELS_PER_WORD  = 5,
  parameter int unsigned NUMBER_OF_PIXELS = 196608,
  parameter int unsigned NUM_FRAMES       = 1,
  parameter int unsigned CYCLES_PER_FRAME = 2084000,
  parameter int unsigned ADDR_STEP        = 1
`ifdef FRAME_UNPACKER_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES   = 1024
`endif
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic                                        start,
  input  logic                                        loop_en,
  input  logic                                        ddr_rd_busy,
  output logic                                        ddr_rd_en,
  output logic [ADDR_W-1:0]                           ddr_addr,
  input  logic                                        ddr_rd_data_valid,
  input  logic [DDR_DATA_WIDTH-1:0]                   ddr_data,
  output logic                                        pix_we,
  output logic [pix_addr_w(NUMBER_OF_PIXELS)-1:0]     pix_addr,
  output logic [PIXEL_WIDTH-1:0]                      pix_data,
  output logic                                        frame_done,
  output logic                                        video_done,
  output logic                                        busy
`ifdef FRAME_UNPACKER_TIMEOUT_EN
  ,
  output logic                                        rd_timeout
`endif
);

  localparam int unsigned PIX_ADDR_W = pix_addr_w(NUMBER_OF_PIXELS);
  localparam int unsigned SLOT_W     = clog2_min1(PIXELS_PER_WORD);
  localparam int unsigned FRAME_W    = clog2_min1(NUM_FRAMES);
  localparam int unsigned USED_W     = PIXELS_PER_WORD * PIXEL_WIDTH;

  localparam logic [PIX_ADDR_W-1:0] LAST_IDX   = PIX_ADDR_W'(NUMBER_OF_PIXELS - 1);
  localparam logic [SLOT_W-1:0]     LAST_SLOT  = SLOT_W'(PIXELS_PER_WORD - 1);
  localparam logic [FRAME_W-1:0]    LAST_FRAME = FRAME_W'(NUM_FRAMES - 1);
  // A zero hold budget skips HOLD entirely.
  localparam state_e AFTER_FRAME = (CYCLES_PER_FRAME == 0) ? REQ : HOLD;

  state_e                  state_q, state_d;
  logic [ADDR_W-1:0]       ddr_addr_q, ddr_addr_d;
  logic [PIX_ADDR_W-1:0]   idx_q, idx_d;
  logic [SLOT_W-1:0]       slot_q, slot_d;
  logic [FRAME_W-1:0]      frame_q, frame_d;
  logic                    pix_we_q, pix_we_d;
  logic                    frame_done_q, frame_done_d;
  logic                    video_done_q, video_done_d;

  logic [USED_W-1:0]       word_q;
  logic [PIX_ADDR_W-1:0]   pix_addr_q;
  logic [PIXEL_WIDTH-1:0]  pix_data_q;
  logic [PIXEL_WIDTH-1:0]  pix_sel;
  logic                    word_load;
  logic                    hold_load;
  logic                    hold_active;
  logic                    hold_done;

  // MSBs above the packed pixels carry no data.
  logic                    unused_ddr_bits;
  assign unused_ddr_bits = ^ddr_data;

`ifdef FRAME_UNPACKER_TIMEOUT_EN
  localparam int unsigned TO_W = clog2_min1(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] LAST_WAIT = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] wait_cnt_q, wait_cnt_d;
  logic            rd_timeout_q, rd_timeout_d;

  assign rd_timeout = rd_timeout_q;
`endif

  assign ddr_rd_en  = (state_q == REQ) && !ddr_rd_busy;
  assign ddr_addr   = ddr_addr_q;
  assign pix_we     = pix_we_q;
  assign pix_addr   = pix_addr_q;
  assign pix_data   = pix_data_q;
  assign frame_done = frame_done_q;
  assign video_done = video_done_q;
  assign busy       = (state_q != IDLE);

  assign word_load   = (state_q == WAIT_VALID) && ddr_rd_data_valid;
  assign hold_active = (state_q == HOLD);
  assign hold_load   = (state_d == HOLD) && (state_q != HOLD);

  frame_unpacker_frame_pacer #(
    .CYCLES_PER_FRAME (CYCLES_PER_FRAME)
  ) u_pacer (
    .clk   (clk),
    .reset (reset),
    .load  (hold_load),
    .en    (hold_active),
    .done  (hold_done)
  );

  always_comb begin
    pix_sel = '0;
    for (int s = 0; s < PIXELS_PER_WORD; s++) begin
      if (slot_q == SLOT_W'(s)) begin
        pix_sel = word_q[s*PIXEL_WIDTH +: PIXEL_WIDTH];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    ddr_addr_d   = ddr_addr_q;
    idx_d        = idx_q;
    slot_d       = slot_q;
    frame_d      = frame_q;
    pix_we_d     = 1'b0;
    frame_done_d = 1'b0;
    video_done_d = 1'b0;
`ifdef FRAME_UNPACKER_TIMEOUT_EN
    rd_timeout_d = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (start) state_d = REQ;
      end

      REQ: begin
        if (!ddr_rd_busy) state_d = WAIT_VALID;
      end

      WAIT_VALID: begin
        if (ddr_rd_data_valid) begin
          slot_d  = '0;
          state_d = UNPACK;
        end
`ifdef FRAME_UNPACKER_TIMEOUT_EN
        else if (wait_cnt_q == LAST_WAIT) begin
          // Re-issue with the unchanged address.
          rd_timeout_d = 1'b1;
          state_d      = REQ;
        end
`endif
      end

      UNPACK: begin
        pix_we_d = 1'b1;
        // Frame end wins over word end: leftover slots of the last word are dropped.
        if (idx_q == LAST_IDX) begin
          idx_d        = '0;
          ddr_addr_d   = ddr_addr_q + ADDR_W'(ADDR_STEP);
          frame_done_d = 1'b1;
          if (frame_q != LAST_FRAME) begin
            frame_d = frame_q + FRAME_W'(1);
            state_d = AFTER_FRAME;
          end else if (loop_en) begin
            ddr_addr_d = '0;
            frame_d    = '0;
            state_d    = AFTER_FRAME;
          end else begin
            ddr_addr_d   = '0;
            frame_d      = '0;
            video_done_d = 1'b1;
            state_d      = IDLE;
          end
        end else begin
          idx_d = idx_q + PIX_ADDR_W'(1);
          if (slot_q == LAST_SLOT) begin
            ddr_addr_d = ddr_addr_q + ADDR_W'(ADDR_STEP);
            state_d    = REQ;
          end else begin
            slot_d = slot_q + SLOT_W'(1);
          end
        end
      end

      HOLD: begin
        if (hold_done) state_d = REQ;
      end

      default: state_d = IDLE;
    endcase
  end

`ifdef FRAME_UNPACKER_TIMEOUT_EN
  assign wait_cnt_d = ((state_q == WAIT_VALID) && (state_d == WAIT_VALID))
                      ? wait_cnt_q + TO_W'(1) : '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      ddr_addr_q   <= '0;
      idx_q        <= '0;
      slot_q       <= '0;
      frame_q      <= '0;
      pix_we_q     <= 1'b0;
      frame_done_q <= 1'b0;
      video_done_q <= 1'b0;
`ifdef FRAME_UNPACKER_TIMEOUT_EN
      wait_cnt_q   <= '0;
      rd_timeout_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      ddr_addr_q   <= ddr_addr_d;
      idx_q        <= idx_d;
      slot_q       <= slot_d;
      frame_q      <= frame_d;
      pix_we_q     <= pix_we_d;
      frame_done_q <= frame_done_d;
      video_done_q <= video_done_d;
`ifdef FRAME_UNPACKER_TIMEOUT_EN
      wait_cnt_q   <= wait_cnt_d;
      rd_timeout_q <= rd_timeout_d;
`endif
    end
  end

  // Datapath registers carry no reset; pix_we qualifies them.
  always_ff @(posedge clk) begin
    if (word_load) begin
      word_q <= ddr_data[USED_W-1:0];
    end
    if (state_q == UNPACK) begin
      pix_data_q <= pix_sel;
      pix_addr_q <= idx_q;
    end
  end

endmodule

// File: tb/tb_frame_unpacker_reader.sv
module tb_frame_unpacker_reader;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         loop_en = 1'b0;
  logic         ddr_rd_busy = 1'b0;
  logic         ddr_rd_en;
  logic [23:0]  ddr_addr;
  logic         ddr_rd_data_valid = 1'b0;
  logic [127:0] ddr_data = '0;
  logic         pix_we;
  logic [3:0]   pix_addr;
  logic [23:0]  pix_data;
  logic         frame_done;
  logic         video_done;
  logic         busy;
`ifdef FRAME_UNPACKER_TIMEOUT_EN
  logic         rd_timeout;
`endif

  int vectors = 0;
  int errs    = 0;

  frame_unpacker_reader #(
    .DDR_DATA_WIDTH   (128),
    .PIXEL_WIDTH      (24),
    .PIXELS_PER_WORD  (5),
    .NUMBER_OF_PIXELS (12),
    .NUM_FRAMES       (2),
    .CYCLES_PER_FRAME (20),
    .ADDR_STEP        (1)
`ifdef FRAME_UNPACKER_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES   (16)
`endif
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .loop_en           (loop_en),
    .ddr_rd_busy       (ddr_rd_busy),
    .ddr_rd_en         (ddr_rd_en),
    .ddr_addr          (ddr_addr),
    .ddr_rd_data_valid (ddr_rd_data_valid),
    .ddr_data          (ddr_data),
    .pix_we            (pix_we),
    .pix_addr          (pix_addr),
    .pix_data          (pix_data),
    .frame_done        (frame_done),
    .video_done        (video_done),
    .busy              (busy)
`ifdef FRAME_UNPACKER_TIMEOUT_EN
    ,
    .rd_timeout        (rd_timeout)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h required %0h", tag, obs, exp);
    end
  endtask

  // Pixel s of the word at DDR address a holds a*16+s+1; MSBs are filler.
  function automatic logic [127:0] make_word(input int a);
    logic [127:0] w;
    w = '0;
    w[127:120] = 8'hA5;
    for (int s = 0; s < 5; s++) w[s*24 +: 24] = 24'(a*16 + s + 1);
    return w;
  endfunction

  task automatic wait_req();
    int n;
    n = 0;
    while (!ddr_rd_en && n < 200) begin
      tick();
      n++;
    end
    chk("req_seen", {63'd0, ddr_rd_en}, 64'd1);
  endtask

  // Called in the REQ cycle with ddr_rd_en high.
  task automatic serve_word(input logic [127:0] d, input int delay);
    tick();
    chk("single_req_pulse", {63'd0, ddr_rd_en}, 64'd0);
    chk("no_we_in_wait", {63'd0, pix_we}, 64'd0);
    for (int i = 0; i < delay; i++) begin
      tick();
      chk("no_we_while_delayed", {63'd0, pix_we}, 64'd0);
    end
    ddr_rd_data_valid = 1'b1;
    ddr_data          = d;
    tick();
    ddr_rd_data_valid = 1'b0;
    ddr_data          = '0;
  endtask

  task automatic check_pixels(input int n, input int first, input int waddr);
    for (int k = 0; k < n; k++) begin
      tick();
      chk("pix_we", {63'd0, pix_we}, 64'd1);
      chk("pix_addr", {60'd0, pix_addr}, 64'(first + k));
      chk("pix_data", {40'd0, pix_data}, 64'(24'(waddr*16 + k + 1)));
      chk("frame_done_at_last", {63'd0, frame_done}, {63'd0, (first + k) == 11});
    end
  endtask

  task automatic play_frame(input int base, input bit bp, input bit vid);
    int n;
    for (int w = 0; w < 3; w++) begin
      if (!(bp && w == 1)) wait_req();
      chk("req_addr", {40'd0, ddr_addr}, 64'(base + w));
      serve_word(make_word(base + w), (bp && w == 1) ? 30 : 0);
      if (bp && w == 0) ddr_rd_busy = 1'b1;
      check_pixels((w == 2) ? 2 : 5, w*5, base + w);
      if (bp && w == 0) begin
        chk("bp_no_req", {63'd0, ddr_rd_en}, 64'd0);
        for (int i = 0; i < 6; i++) begin
          tick();
          chk("bp_no_req", {63'd0, ddr_rd_en}, 64'd0);
        end
        ddr_rd_busy = 1'b0;
        #1;
        chk("bp_release_req", {63'd0, ddr_rd_en}, 64'd1);
      end
    end
    chk("video_done", {63'd0, video_done}, {63'd0, vid});
    if (vid) begin
      chk("end_busy", {63'd0, busy}, 64'd0);
      chk("end_ddr_addr", {40'd0, ddr_addr}, 64'd0);
      tick();
      chk("video_done_pulse", {63'd0, video_done}, 64'd0);
      chk("frame_done_pulse", {63'd0, frame_done}, 64'd0);
    end else begin
      tick();
      n = 1;
      chk("dropped_slots_no_we", {63'd0, pix_we}, 64'd0);
      chk("frame_done_pulse", {63'd0, frame_done}, 64'd0);
      while (!ddr_rd_en && n < 100) begin
        tick();
        n++;
      end
      chk("hold_cycles", 64'(n), 64'd20);
    end
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    chk("rst_pix_we", {63'd0, pix_we}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_rd_en", {63'd0, ddr_rd_en}, 64'd0);
    chk("rst_ddr_addr", {40'd0, ddr_addr}, 64'd0);
    chk("rst_frame_done", {63'd0, frame_done}, 64'd0);
    chk("rst_video_done", {63'd0, video_done}, 64'd0);
    reset = 1'b0;

    // Stale valid in IDLE is ignored
    ddr_rd_data_valid = 1'b1;
    ddr_data          = make_word(9);
    repeat (2) begin
      tick();
      chk("idle_valid_we", {63'd0, pix_we}, 64'd0);
      chk("idle_valid_busy", {63'd0, busy}, 64'd0);
    end
    ddr_rd_data_valid = 1'b0;
    ddr_data          = '0;

    // Frames 0,1 then loop back; frames 0,1 again then one-shot end
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy", {63'd0, busy}, 64'd1);
    loop_en = 1'b0;
    play_frame(0, 1'b0, 1'b0);
    loop_en = 1'b1;
    play_frame(3, 1'b1, 1'b0);
    loop_en = 1'b0;
    play_frame(0, 1'b0, 1'b0);
    play_frame(3, 1'b0, 1'b1);

    // Reset in the middle of UNPACK
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_req();
    serve_word(make_word(0), 0);
    check_pixels(5, 0, 0);
    wait_req();
    serve_word(make_word(1), 0);
    check_pixels(3, 5, 1);
    reset = 1'b1;
    tick();
    chk("midrst_we", {63'd0, pix_we}, 64'd0);
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_ddr_addr", {40'd0, ddr_addr}, 64'd0);
    reset = 1'b0;
    ddr_rd_data_valid = 1'b1;
    ddr_data          = make_word(5);
    repeat (3) begin
      tick();
      chk("stray_valid_we", {63'd0, pix_we}, 64'd0);
      chk("stray_valid_busy", {63'd0, busy}, 64'd0);
    end
    ddr_rd_data_valid = 1'b0;
    ddr_data          = '0;

`ifdef FRAME_UNPACKER_TIMEOUT_EN
    begin
      int n;
      chk("to_idle_pulse", {63'd0, rd_timeout}, 64'd0);
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_req();
      chk("to_first_addr", {40'd0, ddr_addr}, 64'd0);
      tick();
      n = 0;
      while (!ddr_rd_en && n < 40) begin
        tick();
        n++;
      end
      chk("to_reissue_cycles", 64'(n), 64'd16);
      chk("to_pulse", {63'd0, rd_timeout}, 64'd1);
      chk("to_same_addr", {40'd0, ddr_addr}, 64'd0);
      tick();
      chk("to_pulse_width", {63'd0, rd_timeout}, 64'd0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
